// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: ROM port, decode valid/ready handshake, redirect/halt controls and fault flag.
// The master modport is the fetch controller; the slave modport is the ROM/decode side.
interface instr_fetch_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [DATA_WIDTH-1:0] i_rom_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0] o_instr_pc;
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;
  logic                  i_halt;
  logic                  o_fault;

  modport master (
    output o_rom_addr,
    input  i_rom_data,
    output o_valid,
    input  i_ready,
    output o_instr,
    output o_instr_pc,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_halt,
    output o_fault
  );

  modport slave (
    input  o_rom_addr,
    output i_rom_data,
    input  o_valid,
    output i_ready,
    input  o_instr,
    input  o_instr_pc,
    output i_redirect,
    output i_redirect_pc,
    output i_halt,
    input  o_fault
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads a combinational ROM and feeds decode through a 2-entry buffer.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters (o_fetch_cnt, o_stall_cnt).
module instr_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ROM_WORDS  = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  instr_fetch_ctrl_if.master fif
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [1:0]            count_reg, count_next;

  logic [DATA_WIDTH-1:0] entry_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] entry_pc    [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  valid;
  logic                  pop;
  logic                  push;
  logic [1:0]            wr_idx;

  assign word_idx = pc_reg >> 2;
  assign in_range = word_idx < ADDR_WIDTH'(ROM_WORDS);
  assign valid    = (count_reg != 2'd0);
  assign pop      = valid && fif.i_ready;

  // Halt gates the push in the same cycle it rises so the last fetch lands the cycle before.
  assign push = (state_reg == ST_RUN) && !fif.i_halt && !fif.i_redirect && in_range &&
                ((count_reg != 2'd2) || pop);

  // Tail slot after this cycle's pop has shifted the queue down.
  assign wr_idx = count_reg - {1'b0, pop};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    if (fif.i_redirect) begin
      count_next = 2'd0;
      if (fif.i_redirect_pc[1:0] == 2'b00) begin
        pc_next    = fif.i_redirect_pc;
        state_next = fif.i_halt ? ST_HALT : ST_RUN;
      end else begin
        state_next = ST_FAULT;
      end
    end else begin
      count_next = count_reg + {1'b0, push} - {1'b0, pop};
      if (push) begin
        pc_next = pc_reg + ADDR_WIDTH'(4);
      end
      case (state_reg)
        ST_RUN: begin
          if (!in_range) begin
            state_next = ST_FAULT;
          end else if (fif.i_halt) begin
            state_next = ST_HALT;
          end
        end
        ST_HALT: begin
          if (!fif.i_halt) begin
            state_next = ST_RUN;
          end
        end
        ST_FAULT: state_next = ST_FAULT;
        default:  state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
      count_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  // Each slot either captures the ROM word or shifts down from the slot behind it on a pop.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    localparam int SRC = (gi < DEPTH - 1) ? gi + 1 : gi;
    logic [DATA_WIDTH-1:0] instr_reg;
    logic [ADDR_WIDTH-1:0] pc_slot_reg;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        instr_reg   <= '0;
        pc_slot_reg <= '0;
      end else if (push && (wr_idx == 2'(gi))) begin
        instr_reg   <= fif.i_rom_data;
        pc_slot_reg <= pc_reg;
      end else if (pop) begin
        instr_reg   <= entry_instr[SRC];
        pc_slot_reg <= entry_pc[SRC];
      end
    end

    assign entry_instr[gi] = instr_reg;
    assign entry_pc[gi]    = pc_slot_reg;
  end

  assign fif.o_rom_addr = word_idx;
  assign fif.o_valid    = valid;
  assign fif.o_instr    = valid ? entry_instr[0] : '0;
  assign fif.o_instr_pc = valid ? entry_pc[0] : '0;
  assign fif.o_fault    = (state_reg == ST_FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (push && (fetch_cnt_reg != '1)) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if ((state_reg == ST_RUN) && (count_reg == 2'd2) && !pop && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign o_fetch_cnt = fetch_cnt_reg;
  assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a 128-word and a 4-word instance, ROM word k holds k.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_instr_fetch_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();
  instr_fetch_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif4 ();

  assign fif.i_rom_data  = fif.o_rom_addr;
  assign fif4.i_rom_data = fif4.o_rom_addr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt4, stall_cnt4;
`endif

  instr_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_WORDS(128), .RESET_PC(32'h0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fif     (fif)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt (fetch_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  instr_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_WORDS(4), .RESET_PC(32'h0)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fif     (fif4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_fetch_cnt (fetch_cnt4),
    .o_stall_cnt (stall_cnt4)
`endif
  );

  function automatic logic [64:0] obs();
    return {fif.o_valid, fif.o_instr_pc, fif.o_instr};
  endfunction

  function automatic logic [65:0] obs4();
    return {fif4.o_fault, fif4.o_valid, fif4.o_instr_pc, fif4.o_instr};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 0: registers hold reset values and rst_n has just gone high.
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fif.i_ready = 1'b1;
    do_reset();
    repeat (3) next_cycle();
    rst_n = 1'b0;
    fif.i_redirect = 1'b1;
    fif.i_redirect_pc = 32'h42;
    fif.i_halt = 1'b1;
    next_cycle();
    checks++;
    if ({fif.o_valid, fif.o_fault, fif.o_instr_pc, fif.o_instr, fif.o_rom_addr} !== 98'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b fault=%0b pc=%0h instr=%0h addr=%0h, required all 0",
               fif.o_valid, fif.o_fault, fif.o_instr_pc, fif.o_instr, fif.o_rom_addr);
    end else $display("reset_state ok");
    checks++;
    if (obs4() !== 66'd0) begin
      errors++;
      $display("FAIL reset_state4: got %0h, required 0", obs4());
    end else $display("reset_state4 ok");
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({fetch_cnt, stall_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got fetch=%0d stall=%0d, required 0 0", fetch_cnt, stall_cnt);
    end else $display("reset_counters ok");
`endif
    fif.i_redirect = 1'b0;
    fif.i_redirect_pc = '0;
    fif.i_halt = 1'b0;
  endtask

  task automatic test_stream();
    fif.i_ready = 1'b1;
    do_reset();
    checks++;
    if (obs() !== 65'd0) begin
      errors++;
      $display("FAIL stream_cycle0: got %0h, required 0", obs());
    end else $display("stream cycle0 empty ok");
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      checks++;
      if (obs() !== {1'b1, 32'(4 * (k - 1)), 32'(k - 1)}) begin
        errors++;
        $display("FAIL stream_c%0d: got v=%0b pc=%0h instr=%0h, required v=1 pc=%0h instr=%0h",
                 k, fif.o_valid, fif.o_instr_pc, fif.o_instr, 4 * (k - 1), k - 1);
      end else $display("stream cycle %0d pc=%0h instr=%0h", k, fif.o_instr_pc, fif.o_instr);
    end
  endtask

  task automatic test_backpressure();
    fif.i_ready = 1'b0;
    do_reset();
    repeat (4) next_cycle();
    checks++;
    if ({obs(), fif.o_rom_addr} !== {1'b1, 32'h0, 32'h0, 32'd2}) begin
      errors++;
      $display("FAIL bp_full: got v=%0b pc=%0h addr=%0h, required v=1 pc=0 addr=2",
               fif.o_valid, fif.o_instr_pc, fif.o_rom_addr);
    end else $display("backpressure full: head pc=0 rom_addr=2");
    next_cycle();
    checks++;
    if ({obs(), fif.o_rom_addr} !== {1'b1, 32'h0, 32'h0, 32'd2}) begin
      errors++;
      $display("FAIL bp_hold: got v=%0b pc=%0h addr=%0h, required v=1 pc=0 addr=2",
               fif.o_valid, fif.o_instr_pc, fif.o_rom_addr);
    end else $display("backpressure hold ok");
    fif.i_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      checks++;
      if (obs() !== {1'b1, 32'(4 * k), 32'(k)}) begin
        errors++;
        $display("FAIL bp_drain%0d: got v=%0b pc=%0h instr=%0h, required v=1 pc=%0h instr=%0h",
                 k, fif.o_valid, fif.o_instr_pc, fif.o_instr, 4 * k, k);
      end else $display("backpressure drain pc=%0h", fif.o_instr_pc);
    end
  endtask

  task automatic test_redirect();
    fif.i_ready = 1'b0;
    do_reset();
    repeat (2) next_cycle();
    fif.i_redirect = 1'b1;
    fif.i_redirect_pc = 32'h40;
    fif.i_ready = 1'b1;
    next_cycle();
    fif.i_redirect = 1'b0;
    checks++;
    if (obs() !== 65'd0) begin
      errors++;
      $display("FAIL redir_bubble: got v=%0b pc=%0h, required v=0 pc=0", fif.o_valid, fif.o_instr_pc);
    end else $display("redirect bubble ok");
    next_cycle();
    checks++;
    if (obs() !== {1'b1, 32'h40, 32'd16}) begin
      errors++;
      $display("FAIL redir_target: got v=%0b pc=%0h instr=%0h, required v=1 pc=40 instr=10",
               fif.o_valid, fif.o_instr_pc, fif.o_instr);
    end else $display("redirect target pc=40 instr=16");
    next_cycle();
    checks++;
    if (obs() !== {1'b1, 32'h44, 32'd17}) begin
      errors++;
      $display("FAIL redir_next: got v=%0b pc=%0h instr=%0h, required v=1 pc=44 instr=11",
               fif.o_valid, fif.o_instr_pc, fif.o_instr);
    end else $display("redirect follow pc=44");
  endtask

  // Continues from test_redirect: pc is 0x48 at entry.
  task automatic test_fault();
    fif.i_redirect = 1'b1;
    fif.i_redirect_pc = 32'h42;
    next_cycle();
    fif.i_redirect = 1'b0;
    checks++;
    if ({fif.o_fault, obs(), fif.o_rom_addr} !== {1'b1, 65'd0, 32'h12}) begin
      errors++;
      $display("FAIL fault_enter: got fault=%0b v=%0b addr=%0h, required fault=1 v=0 addr=12",
               fif.o_fault, fif.o_valid, fif.o_rom_addr);
    end else $display("fault entered, pc held");
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      checks++;
      if ({fif.o_fault, fif.o_valid} !== 2'b10) begin
        errors++;
        $display("FAIL fault_hold%0d: got fault=%0b v=%0b, required fault=1 v=0", k, fif.o_fault, fif.o_valid);
      end else $display("fault hold %0d", k);
    end
    fif.i_redirect = 1'b1;
    fif.i_redirect_pc = 32'h10;
    next_cycle();
    fif.i_redirect = 1'b0;
    checks++;
    if ({fif.o_fault, fif.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL fault_exit: got fault=%0b v=%0b, required 0 0", fif.o_fault, fif.o_valid);
    end else $display("fault cleared by redirect");
    next_cycle();
    checks++;
    if (obs() !== {1'b1, 32'h10, 32'd4}) begin
      errors++;
      $display("FAIL fault_resume: got v=%0b pc=%0h instr=%0h, required v=1 pc=10 instr=4",
               fif.o_valid, fif.o_instr_pc, fif.o_instr);
    end else $display("resume pc=10 instr=4");
  endtask

  task automatic test_rom_end();
    fif4.i_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      checks++;
      if (obs4() !== {1'b0, 1'b1, 32'(4 * (k - 1)), 32'(k - 1)}) begin
        errors++;
        $display("FAIL romend_c%0d: got fault=%0b v=%0b pc=%0h, required fault=0 v=1 pc=%0h",
                 k, fif4.o_fault, fif4.o_valid, fif4.o_instr_pc, 4 * (k - 1));
      end else $display("rom_end cycle %0d pc=%0h", k, fif4.o_instr_pc);
    end
    next_cycle();
    checks++;
    if ({obs4(), fif4.o_rom_addr} !== {1'b1, 65'd0, 32'd4}) begin
      errors++;
      $display("FAIL romend_fault: got fault=%0b v=%0b addr=%0h, required fault=1 v=0 addr=4",
               fif4.o_fault, fif4.o_valid, fif4.o_rom_addr);
    end else $display("rom_end fault at pc=16");
  endtask

  task automatic test_halt();
    fif4.i_ready = 1'b1;
    do_reset();
    next_cycle();
    next_cycle();
    checks++;
    if (obs4() !== {1'b0, 1'b1, 32'h4, 32'd1}) begin
      errors++;
      $display("FAIL halt_pre: got v=%0b pc=%0h, required v=1 pc=4", fif4.o_valid, fif4.o_instr_pc);
    end else $display("halt pre pc=4");
    fif4.i_halt = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      next_cycle();
      if (k == 5) fif4.i_halt = 1'b0;
      checks++;
      if ({obs4(), fif4.o_rom_addr} !== {66'd0, 32'd2}) begin
        errors++;
        $display("FAIL halt_c%0d: got fault=%0b v=%0b addr=%0h, required fault=0 v=0 addr=2",
                 k, fif4.o_fault, fif4.o_valid, fif4.o_rom_addr);
      end else $display("halt cycle %0d idle, rom_addr=2", k);
    end
    for (int k = 2; k <= 3; k++) begin
      next_cycle();
      checks++;
      if (obs4() !== {1'b0, 1'b1, 32'(4 * k), 32'(k)}) begin
        errors++;
        $display("FAIL halt_resume%0d: got v=%0b pc=%0h, required v=1 pc=%0h",
                 k, fif4.o_valid, fif4.o_instr_pc, 4 * k);
      end else $display("halt resume pc=%0h", fif4.o_instr_pc);
    end
    next_cycle();
    checks++;
    if ({fif4.o_fault, fif4.o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL halt_fault: got fault=%0b v=%0b, required 1 0", fif4.o_fault, fif4.o_valid);
    end else $display("halt run ends in fault");
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    fif.i_ready = 1'b1;
    do_reset();
    repeat (10) next_cycle();
    checks++;
    if ({fetch_cnt, stall_cnt} !== {32'd10, 32'd0}) begin
      errors++;
      $display("FAIL perf_run: got fetch=%0d stall=%0d, required 10 0", fetch_cnt, stall_cnt);
    end else $display("perf after 10 fetches ok");
    fif.i_ready = 1'b0;
    repeat (4) next_cycle();
    checks++;
    if ({fetch_cnt, stall_cnt} !== {32'd11, 32'd3}) begin
      errors++;
      $display("FAIL perf_stall: got fetch=%0d stall=%0d, required 11 3", fetch_cnt, stall_cnt);
    end else $display("perf after stalls fetch=11 stall=3");
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    checks++;
    if ({fetch_cnt, stall_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL perf_reset: got fetch=%0d stall=%0d, required 0 0", fetch_cnt, stall_cnt);
    end else $display("perf counters cleared by reset");
  endtask
`endif

  initial begin
    fif.i_ready = 1'b1;
    fif.i_redirect = 1'b0;
    fif.i_redirect_pc = '0;
    fif.i_halt = 1'b0;
    fif4.i_ready = 1'b1;
    fif4.i_redirect = 1'b0;
    fif4.i_redirect_pc = '0;
    fif4.i_halt = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_rom_end();
    test_halt();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
